icache_resp_collector: RTL and testbench

ICACHE_RESP_COLLECTOR -- requirements
Module: icache_resp_collector

---
 rtl/icache_resp_collector.sv | 152 +++++++++++++++
 tb/tb_icache_resp_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_resp_collector.sv
// Collects two half-line bus responses per slot into a 512-bit icache line write.
// Optional macro ICACHE_RESP_ERR_EN enables per-slot sticky bus-error tracking on line_err.
module icache_resp_collector #(
  parameter logic [5:0] CORENO = 6'd1,
  parameter logic [5:0] CID    = 6'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               resp_v,
  input  logic [5:0]         resp_core,
  input  logic [5:0]         resp_channel,
  input  logic [3:0]         resp_tranid,
  input  logic [255:0]       resp_dat,
  input  logic               resp_err,
  output logic               resp_rdy,
  input  logic [15:0][31:0]  vtags,
  output logic               line_v,
  output logic [31:0]        line_vadr,
  output logic [511:0]       line_dat,
  output logic               line_err,
  input  logic               line_rdy,
  output logic               ack,
  input  logic               snoop_v,
  input  logic [31:0]        snoop_adr,
  input  logic [5:0]         snoop_cid
);

  typedef enum logic {IDLE = 1'b0, OUT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    slot;
  logic          half;
  logic          half_ok;
  logic          acc;
  logic          wr;
  logic          complete;
  logic [3:0][1:0]  hv;
  logic [3:0]       snp_hit;
  logic [3:0]       sel;
  logic [31:0]      slot_tag [4];
  logic [511:0]     slot_dat [4];
  logic [511:0]     cur_dat;
  logic [511:0]     merged;
  logic             unused_bits;

  assign slot    = resp_tranid[3:2];
  assign half    = resp_tranid[0];
  assign half_ok = !resp_tranid[1];

  assign line_v   = (state == OUT);
  assign resp_rdy = !line_v | line_rdy;

  assign acc = resp_v && resp_rdy && (resp_core == CORENO) && (resp_channel == CID) && !rst;
  // A snoop on the addressed slot wins: the response is dropped outright.
  assign wr       = acc && half_ok && !snp_hit[slot];
  assign complete = wr && hv[slot][~half];

  assign cur_dat = slot_dat[slot];
  assign merged  = half ? {resp_dat, cur_dat[255:0]} : {cur_dat[511:256], resp_dat};

  assign unused_bits = ^{vtags, snoop_adr, resp_err};

`ifdef ICACHE_RESP_ERR_EN
  logic [3:0] slot_err;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_slot
    logic [1:0]   v;
    logic [511:0] dbuf;

    assign slot_tag[g] = vtags[g*4];
    assign snp_hit[g]  = snoop_v && (snoop_cid != CID) &&
                         (slot_tag[g][13:6] == snoop_adr[13:6]);
    assign sel[g]      = (slot == 2'(g));
    assign hv[g]       = v;
    assign slot_dat[g] = dbuf;

    always_ff @(posedge clk) begin
      if (rst) begin
        v <= '0;
      end else if (snp_hit[g] || (complete && sel[g])) begin
        v <= '0;
      end else if (wr && sel[g]) begin
        v[half] <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr && sel[g]) begin
        if (half) dbuf[511:256] <= resp_dat;
        else      dbuf[255:0]   <= resp_dat;
      end
    end

`ifdef ICACHE_RESP_ERR_EN
    logic e;
    assign slot_err[g] = e;

    // Error belongs to the fill in progress, so a snoop discards it with the data.
    always_ff @(posedge clk) begin
      if (rst) begin
        e <= 1'b0;
      end else if (snp_hit[g] || (complete && sel[g])) begin
        e <= 1'b0;
      end else if (wr && sel[g] && resp_err) begin
        e <= 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (complete) state_nxt = OUT;
      OUT:     if (line_rdy && !complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_vadr <= '0;
      line_dat  <= '0;
      ack       <= 1'b0;
    end else begin
      ack <= line_v && line_rdy;
      if (complete) begin
        line_vadr <= slot_tag[slot];
        line_dat  <= merged;
      end
    end
  end

`ifdef ICACHE_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      line_err <= 1'b0;
    end else if (complete) begin
      line_err <= slot_err[slot] | resp_err;
    end
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_resp_collector.sv
// Directed self-checking bench for icache_resp_collector (CORENO=1, CID=0).
module tb_icache_resp_collector;

  logic               clk = 1'b0;
  logic               rst;
  logic               resp_v;
  logic [5:0]         resp_core;
  logic [5:0]         resp_channel;
  logic [3:0]         resp_tranid;
  logic [255:0]       resp_dat;
  logic               resp_err;
  logic               resp_rdy;
  logic [15:0][31:0]  vtags;
  logic               line_v;
  logic [31:0]        line_vadr;
  logic [511:0]       line_dat;
  logic               line_err;
  logic               line_rdy;
  logic               ack;
  logic               snoop_v;
  logic [31:0]        snoop_adr;
  logic [5:0]         snoop_cid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] DA = {8{32'hA0A0_0001}};
  localparam logic [255:0] DB = {8{32'hB0B0_0002}};
  localparam logic [255:0] DC = {8{32'hC0C0_0003}};
  localparam logic [255:0] DD = {8{32'hD0D0_0004}};
  localparam logic [255:0] DE = {8{32'hE0E0_0005}};
  localparam logic [255:0] DF = {8{32'hF0F0_0006}};
  localparam logic [31:0]  VT4  = 32'hC040_0100;
  localparam logic [31:0]  VT8  = 32'hC080_0200;
  localparam logic [31:0]  VT12 = 32'hC0C0_0300;

`ifdef ICACHE_RESP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  icache_resp_collector #(.CORENO(6'd1), .CID(6'd0)) dut (
    .clk(clk), .rst(rst), .resp_v(resp_v), .resp_core(resp_core),
    .resp_channel(resp_channel), .resp_tranid(resp_tranid), .resp_dat(resp_dat),
    .resp_err(resp_err), .resp_rdy(resp_rdy), .vtags(vtags), .line_v(line_v),
    .line_vadr(line_vadr), .line_dat(line_dat), .line_err(line_err),
    .line_rdy(line_rdy), .ack(ack), .snoop_v(snoop_v), .snoop_adr(snoop_adr),
    .snoop_cid(snoop_cid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] core, input logic [3:0] tid,
                      input logic [255:0] d, input logic err);
    resp_v = 1'b1; resp_core = core; resp_channel = 6'd0;
    resp_tranid = tid; resp_dat = d; resp_err = err;
    tick();
    resp_v = 1'b0; resp_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; resp_v = 1'b0; snoop_v = 1'b0; line_rdy = 1'b1; resp_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; resp_v = 1'b0; resp_core = '0; resp_channel = '0; resp_tranid = '0;
    resp_dat = '0; resp_err = 1'b0; line_rdy = 1'b1; snoop_v = 1'b0;
    snoop_adr = '0; snoop_cid = '0;
    tick(); tick();
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL rst_line_v got %0b want 0", line_v); end
    n_checks++; if (line_vadr !== 32'h0) begin n_fail++; $display("FAIL rst_vadr got %h want 0", line_vadr); end
    n_checks++; if (line_dat !== 512'h0) begin n_fail++; $display("FAIL rst_dat got %h want 0", line_dat[63:0]); end
    n_checks++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", line_err); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %0b want 0", ack); end
    rst = 1'b0;
  endtask

  task automatic test_basic_line();
    do_reset();
    send(6'd1, 4'b0100, DA, 1'b0);
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL basic_half0_v got %0b want 0", line_v); end
    send(6'd1, 4'b0101, DB, 1'b0);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL basic_v got %0b want 1", line_v); end
    n_checks++; if (line_dat !== {DB, DA}) begin n_fail++; $display("FAIL basic_dat got %h want %h", line_dat[287:224], {DB[31:0], DA[255:224]}); end
    n_checks++; if (line_vadr !== VT4) begin n_fail++; $display("FAIL basic_vadr got %h want %h", line_vadr, VT4); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_early got %0b want 0", ack); end
    tick();
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack got %0b want 1", ack); end
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL basic_v_drop got %0b want 0", line_v); end
    tick();
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse got %0b want 0", ack); end
  endtask

  task automatic test_interleave();
    do_reset();
    send(6'd1, 4'd8,  DA, 1'b0);
    send(6'd1, 4'd12, DB, 1'b0);
    send(6'd1, 4'd13, DC, 1'b0);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL il_s3_v got %0b want 1", line_v); end
    n_checks++; if (line_vadr !== VT12) begin n_fail++; $display("FAIL il_s3_vadr got %h want %h", line_vadr, VT12); end
    n_checks++; if (line_dat !== {DC, DB}) begin n_fail++; $display("FAIL il_s3_dat got %h want %h", line_dat[287:224], {DC[31:0], DB[255:224]}); end
    send(6'd1, 4'd9, DD, 1'b0);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL il_s2_v got %0b want 1", line_v); end
    n_checks++; if (line_vadr !== VT8) begin n_fail++; $display("FAIL il_s2_vadr got %h want %h", line_vadr, VT8); end
    n_checks++; if (line_dat !== {DD, DA}) begin n_fail++; $display("FAIL il_s2_dat got %h want %h", line_dat[287:224], {DD[31:0], DA[255:224]}); end
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL il_ack1 got %0b want 1", ack); end
    tick();
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL il_ack2 got %0b want 1", ack); end
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL il_v_end got %0b want 0", line_v); end
    tick();
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL il_ack_end got %0b want 0", ack); end
  endtask

  task automatic test_backpressure();
    do_reset();
    line_rdy = 1'b0;
    send(6'd1, 4'b0100, DE, 1'b0);
    send(6'd1, 4'b0101, DF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL bp_v[%0d] got %0b want 1", i, line_v); end
      n_checks++; if (line_dat !== {DF, DE} || line_vadr !== VT4) begin n_fail++; $display("FAIL bp_hold[%0d] got %h/%h want %h/%h", i, line_vadr, line_dat[31:0], VT4, DE[31:0]); end
      n_checks++; if (resp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy[%0d] got %0b want 0", i, resp_rdy); end
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL bp_ack[%0d] got %0b want 0", i, ack); end
      tick();
    end
    line_rdy = 1'b1;
    #1;
    n_checks++; if (resp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_rel got %0b want 1", resp_rdy); end
    tick();
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bp_ack_rel got %0b want 1", ack); end
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL bp_v_rel got %0b want 0", line_v); end
  endtask

  task automatic test_filter();
    do_reset();
    send(6'd2, 4'b0100, DA, 1'b0);
    send(6'd1, 4'b0101, DB, 1'b0);
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL flt_core_v got %0b want 0", line_v); end
    send(6'd1, 4'b0110, DC, 1'b0);
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL flt_half2_v got %0b want 0", line_v); end
    send(6'd1, 4'b0100, DD, 1'b0);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL flt_good_v got %0b want 1", line_v); end
    n_checks++; if (line_dat !== {DB, DD}) begin n_fail++; $display("FAIL flt_dat got %h want %h", line_dat[287:224], {DB[31:0], DD[255:224]}); end
  endtask

  task automatic test_snoop();
    do_reset();
    send(6'd1, 4'b0100, DA, 1'b0);
    snoop_v = 1'b1; snoop_adr = 32'h0000_0100; snoop_cid = 6'd1;
    tick();
    snoop_v = 1'b0;
    send(6'd1, 4'b0101, DB, 1'b0);
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL snp_clr_v got %0b want 0", line_v); end
    tick();
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL snp_clr_v2 got %0b want 0", line_v); end
    do_reset();
    send(6'd1, 4'b0100, DA, 1'b0);
    snoop_v = 1'b1; snoop_adr = 32'h0000_0100; snoop_cid = 6'd0;
    tick();
    snoop_v = 1'b0;
    send(6'd1, 4'b0101, DB, 1'b0);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL snp_owncid_v got %0b want 1", line_v); end
    do_reset();
    send(6'd1, 4'b0100, DA, 1'b0);
    snoop_v = 1'b1; snoop_adr = 32'h0000_0100; snoop_cid = 6'd3;
    send(6'd1, 4'b0101, DB, 1'b0);
    snoop_v = 1'b0;
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL snp_prio_v got %0b want 0", line_v); end
    send(6'd1, 4'b0100, DC, 1'b0);
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL snp_prio_v2 got %0b want 0", line_v); end
  endtask

  task automatic test_error();
    do_reset();
    send(6'd1, 4'b0100, DA, 1'b0);
    send(6'd1, 4'b0101, DB, 1'b1);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL err_v got %0b want 1", line_v); end
    n_checks++; if (line_err !== ERR_EXP) begin n_fail++; $display("FAIL err_set got %0b want %0b", line_err, ERR_EXP); end
    send(6'd1, 4'b0100, DC, 1'b0);
    send(6'd1, 4'b0101, DD, 1'b0);
    n_checks++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %0b want 0", line_err); end
  endtask

  task automatic test_reset_mid_out();
    do_reset();
    line_rdy = 1'b0;
    send(6'd1, 4'b0100, DA, 1'b0);
    send(6'd1, 4'b0101, DB, 1'b0);
    n_checks++; if (line_v !== 1'b1) begin n_fail++; $display("FAIL rmo_v got %0b want 1", line_v); end
    rst = 1'b1; line_rdy = 1'b1;
    send(6'd1, 4'd8, DC, 1'b0);
    rst = 1'b0;
    n_checks++; if (line_v !== 1'b0 || line_dat !== 512'h0) begin n_fail++; $display("FAIL rmo_drop got %0b/%h want 0/0", line_v, line_dat[31:0]); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rmo_ack got %0b want 0", ack); end
    send(6'd1, 4'd9, DD, 1'b0);
    n_checks++; if (line_v !== 1'b0) begin n_fail++; $display("FAIL rmo_disc_v got %0b want 0", line_v); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rmo_ack2 got %0b want 0", ack); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      vtags[i[3:0]] = 32'hC000_0000 | (i << 20) | (i << 6);
    test_reset();
    test_basic_line();
    test_interleave();
    test_backpressure();
    test_filter();
    test_snoop();
    test_error();
    test_reset_mid_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
